// File: rtl/vga_timing_gen.sv
// VGA timing generator: line/frame counters, sync decode and registered pixel output stage.
// Optional VGA_OUTPUT_DELAY_EN adds a second output register stage (2-cycle latency vs X/Y).
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit SYNC_LEVEL = 1'b0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PIXEL_COLOR,
    output logic [9:0] CURR_X_PIXEL,
    output logic [9:0] CURR_Y_PIXEL,
    output logic       FRAME_END,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       BLANK_OUT,
    output logic [7:0] RGB_OUT
);

    localparam logic [9:0] H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_LAST  = 10'(H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] H_SY_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_BP_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_LAST  = 10'(V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] V_SY_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_BP_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] FRAME_END_Y = 10'(V_ACTIVE);

    typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} hState_t;
    typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} vState_t;

    hState_t    hState, hStateNext;
    vState_t    vState, vStateNext;
    logic [9:0] xCount, xNext;
    logic [9:0] yCount, yNext;
    logic       lineWrap;
    logic       active;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hState <= H_ACT;
            vState <= V_ACT;
            xCount <= '0;
            yCount <= '0;
        end else begin
            hState <= hStateNext;
            vState <= vStateNext;
            xCount <= xNext;
            yCount <= yNext;
        end
    end

    always_comb begin
        hStateNext = hState;
        vStateNext = vState;
        xNext      = xCount + 10'd1;
        yNext      = yCount;
        lineWrap   = 1'b0;
        case (hState)
            H_ACT:   if (xCount == H_ACT_LAST) hStateNext = H_FP;
            H_FP:    if (xCount == H_FP_LAST)  hStateNext = H_SY;
            H_SY:    if (xCount == H_SY_LAST)  hStateNext = H_BP;
            H_BP:    if (xCount == H_BP_LAST) begin
                         hStateNext = H_ACT;
                         xNext      = '0;
                         lineWrap   = 1'b1;
                     end
            default: hStateNext = H_ACT;
        endcase
        // Vertical machine only moves on the end-of-line wrap.
        if (lineWrap) begin
            yNext = yCount + 10'd1;
            case (vState)
                V_ACT:   if (yCount == V_ACT_LAST) vStateNext = V_FP;
                V_FP:    if (yCount == V_FP_LAST)  vStateNext = V_SY;
                V_SY:    if (yCount == V_SY_LAST)  vStateNext = V_BP;
                V_BP:    if (yCount == V_BP_LAST) begin
                             vStateNext = V_ACT;
                             yNext      = '0;
                         end
                default: vStateNext = V_ACT;
            endcase
        end
    end

    assign active       = (hState == H_ACT) && (vState == V_ACT);
    assign CURR_X_PIXEL = xCount;
    assign CURR_Y_PIXEL = yCount;
    assign FRAME_END    = !RESET && (xCount == 10'd0) && (yCount == FRAME_END_Y);

    logic       hsyncR, vsyncR, blankR;
    logic [7:0] rgbR;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hsyncR <= ~SYNC_LEVEL;
            vsyncR <= ~SYNC_LEVEL;
            blankR <= 1'b1;
            rgbR   <= '0;
        end else begin
            hsyncR <= (hState == H_SY) ? SYNC_LEVEL : ~SYNC_LEVEL;
            vsyncR <= (vState == V_SY) ? SYNC_LEVEL : ~SYNC_LEVEL;
            blankR <= ~active;
            rgbR   <= active ? PIXEL_COLOR : 8'd0;
        end
    end

`ifdef VGA_OUTPUT_DELAY_EN
    logic       hsyncD, vsyncD, blankD;
    logic [7:0] rgbD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hsyncD <= ~SYNC_LEVEL;
            vsyncD <= ~SYNC_LEVEL;
            blankD <= 1'b1;
            rgbD   <= '0;
        end else begin
            hsyncD <= hsyncR;
            vsyncD <= vsyncR;
            blankD <= blankR;
            rgbD   <= rgbR;
        end
    end

    assign HSYNC     = hsyncD;
    assign VSYNC     = vsyncD;
    assign BLANK_OUT = blankD;
    assign RGB_OUT   = rgbD;
`else
    assign HSYNC     = hsyncR;
    assign VSYNC     = vsyncR;
    assign BLANK_OUT = blankR;
    assign RGB_OUT   = rgbR;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: shortened vertical timing, per-cycle reference model plus literal checks.
module tb_vga_timing_gen;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 6, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef VGA_OUTPUT_DELAY_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int RST_CYC = FRAME + 8 * HT + 700;

    logic       CLK, RESET;
    logic [7:0] PIXEL_COLOR;
    logic [9:0] CURR_X_PIXEL, CURR_Y_PIXEL;
    logic       FRAME_END, HSYNC, VSYNC, BLANK_OUT;
    logic [7:0] RGB_OUT;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_LEVEL(1'b0)
    ) dut (
        .CLK(CLK), .RESET(RESET), .PIXEL_COLOR(PIXEL_COLOR),
        .CURR_X_PIXEL(CURR_X_PIXEL), .CURR_Y_PIXEL(CURR_Y_PIXEL),
        .FRAME_END(FRAME_END), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .BLANK_OUT(BLANK_OUT), .RGB_OUT(RGB_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nVec = 0;
    int nErr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: position from cycle counting, outputs from region membership.
    int         mx, my;
    bit         valid;
    logic       rs;
    logic [7:0] cs;
    logic       e1Hs, e1Vs, e1Bl, e2Hs, e2Vs, e2Bl, expFe;
    logic [7:0] e1Rgb, e2Rgb;
    logic [31:0] expTuple, actTuple;

    initial begin
        valid = 1'b0;
        mx = 0;
        my = 0;
        forever begin
            @(posedge CLK);
            rs = RESET;
            cs = PIXEL_COLOR;
            @(negedge CLK);
            if (rs === 1'b1) begin
                {e1Hs, e1Vs, e1Bl, e1Rgb} = {3'b111, 8'd0};
                {e2Hs, e2Vs, e2Bl, e2Rgb} = {3'b111, 8'd0};
                mx = 0;
                my = 0;
                valid = 1'b1;
            end else if (valid) begin
                {e2Hs, e2Vs, e2Bl, e2Rgb} = {e1Hs, e1Vs, e1Bl, e1Rgb};
                e1Hs  = !(mx >= HA + HF && mx < HA + HF + HS);
                e1Vs  = !(my >= VA + VF && my < VA + VF + VS);
                e1Bl  = !(mx < HA && my < VA);
                e1Rgb = e1Bl ? 8'd0 : cs;
                mx = mx + 1;
                if (mx == HT) begin
                    mx = 0;
                    my = my + 1;
                    if (my == VT) my = 0;
                end
            end
            if (valid) begin
                expFe = !rs && (mx == 0) && (my == VA);
                if (LAT == 1)
                    expTuple = {10'(mx), 10'(my), expFe, e1Hs, e1Vs, e1Bl, e1Rgb};
                else
                    expTuple = {10'(mx), 10'(my), expFe, e2Hs, e2Vs, e2Bl, e2Rgb};
                actTuple = {CURR_X_PIXEL, CURR_Y_PIXEL, FRAME_END, HSYNC, VSYNC, BLANK_OUT, RGB_OUT};
                check("cycle_model {x,y,fe,hs,vs,blank,rgb}", actTuple, expTuple);
            end
        end
    end

    // Directed stimulus with hand-computed literal expectations.
    int hsLow, vsLow, rgbFF, rgbZero, feCount, feFirst, feSecond;

    initial begin
        RESET = 1'b1;
        PIXEL_COLOR = 8'd0;
        hsLow = 0; vsLow = 0; rgbFF = 0; rgbZero = 0;
        feCount = 0; feFirst = -1; feSecond = -1;
        repeat (3) @(posedge CLK);
        for (int cyc = 0; cyc < RST_CYC + 400; cyc++) begin
            @(negedge CLK);
            if (cyc == 0) begin
                check("reset_x", 32'(CURR_X_PIXEL), 32'd0);
                check("reset_y", 32'(CURR_Y_PIXEL), 32'd0);
                check("reset_hsync", 32'(HSYNC), 32'd1);
                check("reset_vsync", 32'(VSYNC), 32'd1);
                check("reset_blank", 32'(BLANK_OUT), 32'd1);
                check("reset_rgb", 32'(RGB_OUT), 32'd0);
            end
            if (cyc == 1)         check("x_after_1", 32'(CURR_X_PIXEL), 32'd1);
            if (cyc == 655 + LAT) check("hsync_before", 32'(HSYNC), 32'd1);
            if (cyc == 656 + LAT) check("hsync_first_low", 32'(HSYNC), 32'd0);
            if (cyc == 751 + LAT) check("hsync_last_low", 32'(HSYNC), 32'd0);
            if (cyc == 752 + LAT) check("hsync_after", 32'(HSYNC), 32'd1);
            if (cyc == 799)       check("x_line_end", 32'(CURR_X_PIXEL), 32'd799);
            if (cyc == 800) begin
                check("x_wrap", 32'(CURR_X_PIXEL), 32'd0);
                check("y_step", 32'(CURR_Y_PIXEL), 32'd1);
            end
            if (cyc == 800 + LAT) begin
                check("hsync_low_count", 32'(hsLow), 32'd96);
                check("rgb_ff_count", 32'(rgbFF), 32'd640);
                check("rgb_zero_count", 32'(rgbZero), 32'd160);
            end
            if (cyc == FRAME) check("vsync_low_count", 32'(vsLow), 32'd1600);
            if (cyc == RST_CYC - 100) begin
                check("frame_end_count", 32'(feCount), 32'd2);
                check("frame_end_first", 32'(feFirst), 32'd4800);
                check("frame_end_second", 32'(feSecond), 32'd15200);
                check("frame_period", 32'(feSecond - feFirst), 32'd10400);
            end
            if (cyc == RST_CYC) begin
                check("pre_reset_x", 32'(CURR_X_PIXEL), 32'd700);
                check("pre_reset_y", 32'(CURR_Y_PIXEL), 32'd8);
                check("pre_reset_hsync", 32'(HSYNC), 32'd0);
                check("pre_reset_vsync", 32'(VSYNC), 32'd0);
            end
            if (cyc == RST_CYC + 1) begin
                check("midreset_x", 32'(CURR_X_PIXEL), 32'd0);
                check("midreset_y", 32'(CURR_Y_PIXEL), 32'd0);
                check("midreset_hsync", 32'(HSYNC), 32'd1);
                check("midreset_vsync", 32'(VSYNC), 32'd1);
                check("midreset_frame_end", 32'(FRAME_END), 32'd0);
                check("midreset_rgb", 32'(RGB_OUT), 32'd0);
                check("midreset_blank", 32'(BLANK_OUT), 32'd1);
            end
            if (cyc == RST_CYC + 2) check("restart_x", 32'(CURR_X_PIXEL), 32'd1);

            if (cyc < 800 && HSYNC === 1'b0) hsLow++;
            if (cyc < FRAME && VSYNC === 1'b0) vsLow++;
            if (cyc >= LAT && cyc <= 799 + LAT) begin
                if (RGB_OUT === 8'hFF) rgbFF++;
                if (RGB_OUT === 8'h00) rgbZero++;
            end
            if (cyc <= RST_CYC && FRAME_END === 1'b1) begin
                feCount++;
                if (feFirst < 0) feFirst = cyc;
                else if (feSecond < 0) feSecond = cyc;
            end

            #1;
            RESET = (cyc == 0) ? 1'b0 : (cyc == RST_CYC);
            PIXEL_COLOR = (cyc < 800) ? 8'hFF : 8'((cyc * 37) ^ (cyc >> 3));
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
